// File: rtl/load_seq_ctrl.sv
// load_seq_ctrl: AXI4 read sequencer fetching A/B/(C) operand tiles for one MMA.
// Optional macro LOAD_SEQ_RLAST_CHECK_EN enables rlast-vs-count checking.
package params;
  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } type_t;
  typedef logic [1:0] rc_t;
  typedef enum logic [1:0] {
    MAT_A = 2'd0,
    MAT_B = 2'd1,
    MAT_C = 2'd2
  } mat_t;
endpackage

module load_seq_ctrl
  import params::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  type_t             cfg_type,
  input  rc_t               cfg_rc,
  input  logic              cfg_use_c,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [255:0]      m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [255:0]      trans_data,
  output logic [5:0]        trans_burst_num,
  output mat_t              trans_mat,
  output type_t             trans_type,
  output rc_t               trans_rc,
  output logic              trans_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE, AR_A, R_A, AR_B, R_B, AR_C, R_C, ERR
  } state_t;

  state_t            state;
  type_t             type_q;
  rc_t               rc_q;
  logic              use_c_q;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [ADDR_W-1:0] base_c_q;
  logic [5:0]        cnt;
  logic              bad_q;

  mat_t       cur_mat;
  logic [6:0] nbeats;
  logic [5:0] last_idx;
  logic       in_r;
  logic       r_fire;
  logic       is_last;
  logic       resp_bad;
  logic       rlast_bad;
  logic       beat_bad;
  logic       fail_now;

  function automatic logic [6:0] beats_of(
    mat_t m, type_t t, rc_t rc
  );
    logic [6:0] n;
    n = 7'd8;
    case (m)
      MAT_A:
        case (t)
          FP32:    n = 7'd16;
          INT8:    n = (rc == 2'b00) ? 7'd64 : 7'd8;
          default: n = 7'd8;
        endcase
      MAT_B:
        case (t)
          FP32:    n = 7'd8;
          FP16:    n = (rc == 2'b00) ? 7'd16 : 7'd8;
          INT8:    n = (rc == 2'b10) ? 7'd8 : 7'd16;
          default: n = 7'd16;
        endcase
      default: n = 7'd32;
    endcase
    return n;
  endfunction

  // Which matrix the current state is working on.
  always_comb begin
    cur_mat = MAT_A;
    in_r    = 1'b0;
    unique case (state)
      R_A:       in_r = 1'b1;
      AR_B:      cur_mat = MAT_B;
      R_B: begin
        cur_mat = MAT_B;
        in_r    = 1'b1;
      end
      AR_C:      cur_mat = MAT_C;
      R_C: begin
        cur_mat = MAT_C;
        in_r    = 1'b1;
      end
      default:   cur_mat = MAT_A;
    endcase
  end

  // Address/length and per-beat checks derived from latched config.
  always_comb begin
    nbeats   = beats_of(cur_mat, type_q, rc_q);
    last_idx = 6'(nbeats - 7'd1);
    m_arlen  = {1'b0, nbeats} - 8'd1;
    case (cur_mat)
      MAT_B:   m_araddr = base_b_q;
      MAT_C:   m_araddr = base_c_q;
      default: m_araddr = base_a_q;
    endcase
    r_fire   = m_rvalid & in_r;
    is_last  = (cnt == last_idx);
    resp_bad = (m_rresp != 2'b00);
`ifdef LOAD_SEQ_RLAST_CHECK_EN
    rlast_bad = (m_rlast != is_last);
`else
    rlast_bad = 1'b0;
`endif
    beat_bad = resp_bad | rlast_bad;
    fail_now = bad_q | beat_bad;
  end

  assign m_arsize   = 3'b101;
  assign m_arburst  = 2'b01;
  assign m_arvalid  = (state == AR_A) | (state == AR_B) |
                      (state == AR_C);
  assign m_rready   = in_r;
  assign busy       = (state != IDLE);
  assign trans_type = type_q;
  assign trans_rc   = rc_q;

  // Sequencer FSM with registered beat, done and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      type_q          <= FP32;
      rc_q            <= 2'b00;
      use_c_q         <= 1'b0;
      base_a_q        <= '0;
      base_b_q        <= '0;
      base_c_q        <= '0;
      cnt             <= '0;
      bad_q           <= 1'b0;
      trans_data      <= '0;
      trans_burst_num <= '0;
      trans_mat       <= MAT_A;
      trans_valid     <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      err_code        <= 2'b00;
    end else begin
      trans_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cfg_rc == 2'b11) begin
              err      <= 1'b1;
              err_code <= 2'b11;
            end else begin
              type_q   <= cfg_type;
              rc_q     <= cfg_rc;
              use_c_q  <= cfg_use_c;
              base_a_q <= base_a;
              base_b_q <= base_b;
              base_c_q <= base_c;
              err_code <= 2'b00;
              state    <= AR_A;
            end
          end
        end
        AR_A, AR_B, AR_C: begin
          if (m_arready) begin
            cnt   <= '0;
            bad_q <= 1'b0;
            case (state)
              AR_A:    state <= R_A;
              AR_B:    state <= R_B;
              default: state <= R_C;
            endcase
          end
        end
        R_A, R_B, R_C: begin
          if (r_fire) begin
            cnt   <= cnt + 6'd1;
            bad_q <= fail_now;
            if (!fail_now) begin
              trans_valid     <= 1'b1;
              trans_data      <= m_rdata;
              trans_burst_num <= cnt;
              trans_mat       <= cur_mat;
            end
            if (resp_bad)
              err_code <= 2'b01;
            else if (rlast_bad && err_code == 2'b00)
              err_code <= 2'b10;
            if (is_last) begin
              if (fail_now) begin
                state <= ERR;
              end else begin
                case (state)
                  R_A: state <= AR_B;
                  R_B: begin
                    if (use_c_q) begin
                      state <= AR_C;
                    end else begin
                      done  <= 1'b1;
                      state <= IDLE;
                    end
                  end
                  default: begin
                    done  <= 1'b1;
                    state <= IDLE;
                  end
                endcase
              end
            end
          end
        end
        default: begin
          err   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
